// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised CPU register file with a per-register busy scoreboard.
//   Two combinational read ports, one synchronous write port, optional
//   hardwired-zero register 0 and optional write-to-read bypass. A reserve
//   handshake lets a multi-cycle op mark its destination pending until the
//   matching write lands.
//
// Ports
//   clk, rst           clock (posedge) and asynchronous active-high reset
//   we/waddr/wdata     writeback port
//   rs1/rs2            read addresses
//   rs1_data/rs2_data  read data (combinational)
//   rs1_busy/rs2_busy  pending-write flag of the addressed register
//   rsv_valid/rsv_addr reserve request
//   rsv_ready          reservation accepted this cycle (combinational)
//   busy_vec           registered busy bits, bit i = register i
//   reg_dump           registered contents, reg i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [ADDR_W-1:0]          rs1,
   input  logic [ADDR_W-1:0]          rs2,
   output logic [DATA_W-1:0]          rs1_data,
   output logic [DATA_W-1:0]          rs2_data,
   output logic                       rs1_busy,
   output logic                       rs2_busy,
   input  logic                       rsv_valid,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic                       rsv_ready,
   output logic [NUM_REGS-1:0]        busy_vec,
   output logic [NUM_REGS*DATA_W-1:0] reg_dump
);

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              wr_ok;
   logic              rsv_take;
   logic              rs1_hit;
   logic              rs2_hit;

   // An address names real storage only if it is in range and is not the
   // hardwired zero register; everything else reads 0 and is never busy.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      logic ok;
      ok = ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
      if (ZERO_REG && (a == {ADDR_W{1'b0}})) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   // Write qualification, bypass hits and the reserve handshake.
   always_comb begin
      wr_ok     = we & addr_ok(waddr);
      rs1_hit   = BYPASS & wr_ok & (waddr == rs1);
      rs2_hit   = BYPASS & wr_ok & (waddr == rs2);
      rsv_ready = 1'b1;
      if (addr_ok(rsv_addr)) begin
         // a same-cycle write frees the register, so it may be re-reserved
         rsv_ready = ~busy_vec[rsv_addr] | (wr_ok & (waddr == rsv_addr));
      end else begin
         rsv_ready = 1'b1;
      end
      rsv_take = rsv_valid & rsv_ready & addr_ok(rsv_addr);
   end

   // Read port 1: bypass first, then storage, else zero.
   always_comb begin
      rs1_data = {DATA_W{1'b0}};
      rs1_busy = 1'b0;
      if (rs1_hit) begin
         rs1_data = wdata;
      end else if (addr_ok(rs1)) begin
         rs1_data = mem[rs1];
         rs1_busy = busy_vec[rs1];
      end else begin
         rs1_data = {DATA_W{1'b0}};
      end
   end

   // Read port 2: bypass first, then storage, else zero.
   always_comb begin
      rs2_data = {DATA_W{1'b0}};
      rs2_busy = 1'b0;
      if (rs2_hit) begin
         rs2_data = wdata;
      end else if (addr_ok(rs2)) begin
         rs2_data = mem[rs2];
         rs2_busy = busy_vec[rs2];
      end else begin
         rs2_data = {DATA_W{1'b0}};
      end
   end

   // Register storage and scoreboard; a reserve beats a same-cycle write
   // on the busy bit so the new owner keeps the register pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= {DATA_W{1'b0}};
         end
         busy_vec <= {NUM_REGS{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (waddr == ADDR_W'(i))) begin
               mem[i] <= wdata;
            end
            if (rsv_take && (rsv_addr == ADDR_W'(i))) begin
               busy_vec[i] <= 1'b1;
            end else if (wr_ok && (waddr == ADDR_W'(i))) begin
               busy_vec[i] <= 1'b0;
            end
         end
      end
   end

   // Flatten storage for the debug dump (no bypass applied).
   always_comb begin
      reg_dump = {(NUM_REGS*DATA_W){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_dump[i*DATA_W +: DATA_W] = mem[i];
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard. Three instances:
//     a_ : 8x4, BYPASS=1, ZERO_REG=0 (default)
//     b_ : 8x4, BYPASS=0, ZERO_REG=0 (shares inputs with a_)
//     z_ : 16x8, BYPASS=1, ZERO_REG=1
//   Expected values are queued when stimulus is applied and popped when the
//   corresponding output is sampled.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic clk_run = 1'b1;
   logic rst;

   logic       we, rsv_valid;
   logic [1:0] waddr, rs1, rs2, rsv_addr;
   logic [7:0] wdata;
   logic [7:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
   logic       a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
   logic       a_rsv_ready, b_rsv_ready;
   logic [3:0] a_busy_vec, b_busy_vec;
   logic [31:0] a_reg_dump, b_reg_dump;

   logic        z_we, z_rsv_valid;
   logic [2:0]  z_waddr, z_rs1, z_rs2, z_rsv_addr;
   logic [15:0] z_wdata, z_rs1_data, z_rs2_data;
   logic        z_rs1_busy, z_rs2_busy, z_rsv_ready;
   logic [7:0]  z_busy_vec;
   logic [127:0] z_reg_dump;

   logic [31:0] exp_q[$];
   logic [31:0] exp;
   int checks = 0;
   int errors = 0;

   regfile_scoreboard #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rs1(rs1), .rs2(rs2), .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
      .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(a_rsv_ready),
      .busy_vec(a_busy_vec), .reg_dump(a_reg_dump));

   regfile_scoreboard #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rs1(rs1), .rs2(rs2), .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
      .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(b_rsv_ready),
      .busy_vec(b_busy_vec), .reg_dump(b_reg_dump));

   regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
      .clk(clk), .rst(rst), .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
      .rs1(z_rs1), .rs2(z_rs2), .rs1_data(z_rs1_data), .rs2_data(z_rs2_data),
      .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy),
      .rsv_valid(z_rsv_valid), .rsv_addr(z_rsv_addr), .rsv_ready(z_rsv_ready),
      .busy_vec(z_busy_vec), .reg_dump(z_reg_dump));

   // Clock can be frozen (low) to exercise asynchronous reset.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00; rs1 = 2'd0; rs2 = 2'd0;
      rsv_valid = 1'b0; rsv_addr = 2'd0;
      z_we = 1'b0; z_waddr = 3'd0; z_wdata = 16'h0; z_rs1 = 3'd0; z_rs2 = 3'd0;
      z_rsv_valid = 1'b0; z_rsv_addr = 3'd0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (a_reg_dump !== exp) begin errors++; $display("FAIL rst_dump got %h exp %h", a_reg_dump, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL rst_busy got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL rst_rs1 got %h exp %h", a_rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if (z_reg_dump[31:0] !== exp) begin errors++; $display("FAIL rst_zdump got %h exp %h", z_reg_dump[31:0], exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, z_busy_vec} !== exp) begin errors++; $display("FAIL rst_zbusy got %h exp %h", z_busy_vec, exp); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_write_read();
      @(negedge clk); we = 1'b1; waddr = 2'd2; wdata = 8'hA5;
      exp_q.push_back(32'hA5); exp_q.push_back(32'hA5); exp_q.push_back(32'hA5); exp_q.push_back(32'h0);
      @(negedge clk); we = 1'b0; rs1 = 2'd2; rs2 = 2'd2; #1;
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL wr_rs1 got %h exp %h", a_rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs2_data} !== exp) begin errors++; $display("FAIL wr_rs2 got %h exp %h", a_rs2_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_reg_dump[23:16]} !== exp) begin errors++; $display("FAIL wr_dump got %h exp %h", a_reg_dump[23:16], exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rs1_busy} !== exp) begin errors++; $display("FAIL wr_busy got %h exp %h", a_rs1_busy, exp); end
   endtask

   task automatic test_bypass();
      @(negedge clk); we = 1'b1; waddr = 2'd3; wdata = 8'h81;
      @(negedge clk); wdata = 8'h3C; rs1 = 2'd3;
      exp_q.push_back(32'h3C); exp_q.push_back(32'h81); exp_q.push_back(32'h3C);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL byp_on got %h exp %h", a_rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, b_rs1_data} !== exp) begin errors++; $display("FAIL byp_off got %h exp %h", b_rs1_data, exp); end
      @(negedge clk); we = 1'b0; #1;
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, b_rs1_data} !== exp) begin errors++; $display("FAIL byp_after got %h exp %h", b_rs1_data, exp); end
   endtask

   task automatic test_reserve();
      @(negedge clk); rsv_valid = 1'b1; rsv_addr = 2'd1; rs1 = 2'd1;
      exp_q.push_back(32'h1);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rsv_ready} !== exp) begin errors++; $display("FAIL rsv_first got %h exp %h", a_rsv_ready, exp); end
      @(negedge clk);
      exp_q.push_back(32'h2); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL rsv_vec got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rs1_busy} !== exp) begin errors++; $display("FAIL rsv_rs1busy got %h exp %h", a_rs1_busy, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rsv_ready} !== exp) begin errors++; $display("FAIL rsv_second got %h exp %h", a_rsv_ready, exp); end
      @(negedge clk); rsv_valid = 1'b0; we = 1'b1; waddr = 2'd1; wdata = 8'h11;
      exp_q.push_back(32'h2); exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL rsv_hold got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rs1_busy} !== exp) begin errors++; $display("FAIL rsv_bypbusy got %h exp %h", a_rs1_busy, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, b_rs1_busy} !== exp) begin errors++; $display("FAIL rsv_nobypbusy got %h exp %h", b_rs1_busy, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rsv_ready} !== exp) begin errors++; $display("FAIL rsv_wrready got %h exp %h", a_rsv_ready, exp); end
      @(negedge clk); we = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h11);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL rsv_clear got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL rsv_data got %h exp %h", a_rs1_data, exp); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); rsv_valid = 1'b1; rsv_addr = 2'd1;
      @(negedge clk); we = 1'b1; waddr = 2'd1; wdata = 8'h22;
      exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h22);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rsv_ready} !== exp) begin errors++; $display("FAIL b2b_ready got %h exp %h", a_rsv_ready, exp); end
      // different registers in the same cycle: write r2, reserve r3
      @(negedge clk); waddr = 2'd2; wdata = 8'h5A; rsv_addr = 2'd3;
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL b2b_vec got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_reg_dump[15:8]} !== exp) begin errors++; $display("FAIL b2b_r1 got %h exp %h", a_reg_dump[15:8], exp); end
      exp_q.push_back(32'hA); exp_q.push_back(32'h5A);
      @(negedge clk); we = 1'b0; rsv_valid = 1'b0; #1;
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL diff_vec got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_reg_dump[23:16]} !== exp) begin errors++; $display("FAIL diff_r2 got %h exp %h", a_reg_dump[23:16], exp); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk); z_we = 1'b1; z_waddr = 3'd0; z_wdata = 16'hFFFF;
      z_rsv_valid = 1'b1; z_rsv_addr = 3'd0; z_rs1 = 3'd0;
      exp_q.push_back(32'h1); exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, z_rsv_ready} !== exp) begin errors++; $display("FAIL z_ready got %h exp %h", z_rsv_ready, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({16'h0, z_rs1_data} !== exp) begin errors++; $display("FAIL z_r0byp got %h exp %h", z_rs1_data, exp); end
      @(negedge clk); z_rsv_valid = 1'b0; z_waddr = 3'd7; z_wdata = 16'h1234; z_rs2 = 3'd7;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1234);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, z_busy_vec} !== exp) begin errors++; $display("FAIL z_busy got %h exp %h", z_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({16'h0, z_reg_dump[15:0]} !== exp) begin errors++; $display("FAIL z_r0 got %h exp %h", z_reg_dump[15:0], exp); end
      exp = exp_q.pop_front(); checks++;
      if ({16'h0, z_rs2_data} !== exp) begin errors++; $display("FAIL z_r7byp got %h exp %h", z_rs2_data, exp); end
      @(negedge clk); z_we = 1'b0;
      exp_q.push_back(32'h1234);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({16'h0, z_reg_dump[127:112]} !== exp) begin errors++; $display("FAIL z_r7 got %h exp %h", z_reg_dump[127:112], exp); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk); clk_run = 1'b0; rs1 = 2'd2; rs2 = 2'd3; we = 1'b0;
      #2; rst = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (a_reg_dump !== exp) begin errors++; $display("FAIL mid_dump got %h exp %h", a_reg_dump, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({28'h0, a_busy_vec} !== exp) begin errors++; $display("FAIL mid_busy got %h exp %h", a_busy_vec, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL mid_rs1 got %h exp %h", a_rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'h0, a_rs2_busy} !== exp) begin errors++; $display("FAIL mid_rs2busy got %h exp %h", a_rs2_busy, exp); end
      exp = exp_q.pop_front(); checks++;
      if (z_reg_dump[127:96] !== exp) begin errors++; $display("FAIL mid_zdump got %h exp %h", z_reg_dump[127:96], exp); end
      // bypass still forwards during reset
      we = 1'b1; waddr = 2'd2; wdata = 8'h77;
      exp_q.push_back(32'h77); exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, a_rs1_data} !== exp) begin errors++; $display("FAIL mid_byp got %h exp %h", a_rs1_data, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({24'h0, b_rs1_data} !== exp) begin errors++; $display("FAIL mid_nobyp got %h exp %h", b_rs1_data, exp); end
      we = 1'b0; #1; rst = 1'b0; #1; clk_run = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_reserve();
      test_back_to_back();
      test_zero_reg();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the 4x8 CPU register file.
- Configurable width and depth; two combinational read ports and one synchronous write port.
- Adds asynchronous reset to zero, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register busy scoreboard with a reserve handshake, so multi-cycle ops can mark a destination pending until its write lands.
- Sits between the decode stage (reserve, read) and writeback (write) of the CPU datapath.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of registers; must be >= 2.
- ADDR_W, $clog2(NUM_REGS), address width.
- ZERO_REG, 0: if 1, register 0 always reads 0; writes and reserves to it are ignored.
- BYPASS, 1: if 1, a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rs1  in  ADDR_W  read address, port 1.
- rs2  in  ADDR_W  read address, port 2.
- rs1_data  out  DATA_W  read data, port 1 (combinational).
- rs2_data  out  DATA_W  read data, port 2 (combinational).
- rs1_busy  out  1  rs1 has a pending write (combinational).
- rs2_busy  out  1  rs2 has a pending write (combinational).
- rsv_valid  in  1  request to reserve rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle (combinational).
- busy_vec  out  NUM_REGS  registered busy bits; bit i = register i.
- reg_dump  out  NUM_REGS*DATA_W  registered contents; reg i at [i*DATA_W +: DATA_W]; no bypass applied.

Behaviour:
- Reset: while rst is high, all registers, busy_vec and reg_dump are 0 immediately (asynchronous).
  - rs*_data and rs*_busy then read 0, except that a bypass hit still forwards wdata while we is high.
  - Reset mid-operation discards all reservations.
- Write:
  - On posedge, if we=1 and the address is valid, registers[waddr] <= wdata and busy[waddr] <= 0.
  - A write is valid when waddr < NUM_REGS and not (ZERO_REG and waddr==0).
- Read:
  - rsX_data = registers[rsX], zero latency.
  - If BYPASS=1 and the write is valid and waddr==rsX, rsX_data = wdata.
  - With ZERO_REG=1, rsX==0 always returns 0.
  - An out-of-range address returns 0.
- Busy:
  - rsX_busy = busy[rsX], forced to 0 when BYPASS=1 and a valid write hits rsX in the same cycle.
  - rsX_busy is 0 for out-of-range addresses and for the zero register.
- Reserve handshake:
  - rsv_ready = !busy[rsv_addr] | (we & waddr==rsv_addr & write valid).
  - A transfer occurs when rsv_valid & rsv_ready; it sets busy[rsv_addr] <= 1 on posedge.
  - rsv_ready does not depend on rsv_valid.
  - Reserve of a busy register without a same-cycle write: rsv_ready=0, state unchanged; the requester holds.
  - Reserve of the zero register (ZERO_REG=1) or an out-of-range address: rsv_ready=1, no state change.
- Simultaneous events:
  - Write and reserve to the same register: the data is written, busy ends at 1 (reserve wins).
  - Write and reserve to different registers: both take effect.
  - Write to a non-busy register is legal (plain write); busy stays 0.
- Width rules:
  - Data is stored unmodified; no arithmetic.
  - Address bits above NUM_REGS range are treated as out-of-range, never aliased.

Test Plan:
- Reset while registers hold non-zero values, with clk stopped -> reg_dump=0, busy_vec=0 before the next edge; reads return 0.
- Write 0xA5 to r2, then read rs1=2, rs2=2 next cycle -> both 0xA5; reg_dump[23:16]=0xA5.
- BYPASS=1, we=1, waddr=3, wdata=0x3C, rs1=3 in the same cycle -> rs1_data=0x3C combinationally; BYPASS=0 -> old value.
- Reserve r1 (rsv_ready=1) -> busy_vec=4'b0010, rs1_busy=1.
  - Second reserve of r1 -> rsv_ready=0.
  - Write 0x11 to r1 -> busy_vec=0, r1=0x11.
- Same cycle: busy r1, write r1=0x22, reserve r1 -> rsv_ready=1; after the edge r1=0x22, busy_vec[1]=1.
- ZERO_REG=1, DATA_W=16, NUM_REGS=8: write 0xFFFF to r0 and reserve r0 -> r0 reads 0, busy_vec=0, rsv_ready=1.
  - Write r7=0x1234 -> reg_dump[127:112]=0x1234.
